// File: rtl/piece_ram_writer_pkg.sv
// ============================================================================
//  Module      : piece_ram_writer_pkg
//  Description : Shared mode encodings, FSM state enum and default board
//                dimensions for the piece RAM writer and its address helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package piece_ram_writer_pkg;

  localparam int DEF_BOARD_W = 10;
  localparam int DEF_BOARD_H = 24;
  localparam int DEF_DATA_W  = 6;
  localparam int DEF_CELLS   = 4;
  localparam int DEF_OFF_W   = 2;

  typedef enum logic [1:0] {
    MODE_STAMP = 2'd0,
    MODE_ERASE = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WRITE  = 3'd2,
    HOLD   = 3'd3,
    WAIT   = 3'd4,
    SAMPLE = 3'd5,
    DONE   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/piece_ram_writer_if.sv
// ============================================================================
//  Module      : piece_ram_writer_if
//  Description : Command, board-RAM and status bundle of the piece RAM writer.
//                slave = writer side, master = game FSM / RAM side.
//                Optional macro PIECE_WRITER_STATS_EN adds o_cells_hit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface piece_ram_writer_if
  import piece_ram_writer_pkg::*;
#(
  parameter int BOARD_W = DEF_BOARD_W,
  parameter int BOARD_H = DEF_BOARD_H,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CELLS   = DEF_CELLS,
  parameter int OFF_W   = DEF_OFF_W
);

  localparam int XW = $clog2(BOARD_W);
  localparam int YW = $clog2(BOARD_H);
  localparam int AW = $clog2(BOARD_W * BOARD_H);
  localparam int HW = $clog2(CELLS + 1);

  logic                   i_start;
  logic [1:0]             i_mode;
  logic [XW-1:0]          i_x_anc;
  logic [YW-1:0]          i_y_anc;
  logic [CELLS*OFF_W-1:0] i_x_off;
  logic [CELLS*OFF_W-1:0] i_y_off;
  logic [DATA_W-1:0]      i_color;
  logic [AW-1:0]          o_ram_addr;
  logic                   o_ram_wren;
  logic [DATA_W-1:0]      o_ram_wdata;
  logic [DATA_W-1:0]      i_ram_rdata;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_collision;
  logic                   o_oob;
`ifdef PIECE_WRITER_STATS_EN
  logic [HW-1:0]          o_cells_hit;
`endif

  modport slave (
    input  i_start, i_mode, i_x_anc, i_y_anc, i_x_off, i_y_off, i_color,
    input  i_ram_rdata,
    output o_ram_addr, o_ram_wren, o_ram_wdata,
`ifdef PIECE_WRITER_STATS_EN
    output o_cells_hit,
`endif
    output o_busy, o_done, o_collision, o_oob
  );

  modport master (
    output i_start, i_mode, i_x_anc, i_y_anc, i_x_off, i_y_off, i_color,
    output i_ram_rdata,
    input  o_ram_addr, o_ram_wren, o_ram_wdata,
`ifdef PIECE_WRITER_STATS_EN
    input  o_cells_hit,
`endif
    input  o_busy, o_done, o_collision, o_oob
  );

endinterface

`default_nettype wire

// File: rtl/piece_ram_writer_board_addr_calc.sv
// ============================================================================
//  Module      : board_addr_calc
//  Description : Combinational cell address: (anchor + offset) -> linear
//                board address y*BOARD_W + x, plus an in-bounds flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_addr_calc
  import piece_ram_writer_pkg::*;
#(
  parameter int BOARD_W = DEF_BOARD_W,
  parameter int BOARD_H = DEF_BOARD_H,
  parameter int OFF_W   = DEF_OFF_W
) (
  input  logic [$clog2(BOARD_W)-1:0]         i_x_anc,
  input  logic [$clog2(BOARD_H)-1:0]         i_y_anc,
  input  logic [OFF_W-1:0]                   i_x_off,
  input  logic [OFF_W-1:0]                   i_y_off,
  output logic [$clog2(BOARD_W*BOARD_H)-1:0] o_addr,
  output logic                               o_in_bounds
);

  localparam int XW = $clog2(BOARD_W);
  localparam int YW = $clog2(BOARD_H);
  localparam int AW = $clog2(BOARD_W * BOARD_H);

  localparam logic [XW:0] c_MAX_X = (XW+1)'(BOARD_W);
  localparam logic [YW:0] c_MAX_Y = (YW+1)'(BOARD_H);

  // One extra bit so that anchor+offset past the edge cannot wrap back in.
  logic [XW:0] w_cx;
  logic [YW:0] w_cy;

  assign w_cx = {1'b0, i_x_anc} + (XW+1)'(i_x_off);
  assign w_cy = {1'b0, i_y_anc} + (YW+1)'(i_y_off);

  assign o_in_bounds = (w_cx < c_MAX_X) && (w_cy < c_MAX_Y);
  // Only meaningful when in bounds; the caller ignores it otherwise.
  assign o_addr      = AW'(w_cy) * AW'(BOARD_W) + AW'(w_cx);

endmodule

`default_nettype wire

// File: rtl/piece_ram_writer.sv
// ============================================================================
//  Module      : piece_ram_writer
//  Description : Walks the CELLS cells of one piece and stamps (colour),
//                erases (zero) or checks (collision) them in the board RAM.
//                Optional macro PIECE_WRITER_STATS_EN adds a cells_hit count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piece_ram_writer
  import piece_ram_writer_pkg::*;
#(
  parameter int BOARD_W    = DEF_BOARD_W,
  parameter int BOARD_H    = DEF_BOARD_H,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CELLS      = DEF_CELLS,
  parameter int OFF_W      = DEF_OFF_W,
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  piece_ram_writer_if.slave  bus
);

  localparam int XW = $clog2(BOARD_W);
  localparam int YW = $clog2(BOARD_H);
  localparam int AW = $clog2(BOARD_W * BOARD_H);
  localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_mode;
  logic [XW-1:0]          r_x_anc;
  logic [YW-1:0]          r_y_anc;
  logic [CELLS*OFF_W-1:0] r_x_off;
  logic [CELLS*OFF_W-1:0] r_y_off;
  logic [DATA_W-1:0]      r_color;
  logic [IW-1:0]          r_idx;
  logic [WW-1:0]          r_wait;
  logic [AW-1:0]          r_ram_addr;
  logic                   r_ram_wren;
  logic [DATA_W-1:0]      r_ram_wdata;
  logic                   r_collision;
  logic                   r_oob;
  logic                   w_busy;
  logic                   w_done;

  logic [OFF_W-1:0]       w_x_off;
  logic [OFF_W-1:0]       w_y_off;
  logic [AW-1:0]          w_addr;
  logic                   w_inb;
  logic                   w_is_check;
  logic                   w_last;
  logic                   w_last_wait;

  // Reserved mode 3 behaves as CHECK.
  assign w_is_check  = (r_mode == MODE_CHECK) || (r_mode == MODE_RSVD);
  assign w_last      = (r_idx == IW'(CELLS - 1));
  assign w_last_wait = (r_wait == WW'(RD_LATENCY - 1));
  assign w_x_off     = r_x_off[r_idx*OFF_W +: OFF_W];
  assign w_y_off     = r_y_off[r_idx*OFF_W +: OFF_W];

  board_addr_calc #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H),
    .OFF_W   (OFF_W)
  ) u_calc (
    .i_x_anc     (r_x_anc),
    .i_y_anc     (r_y_anc),
    .i_x_off     (w_x_off),
    .i_y_off     (w_y_off),
    .o_addr      (w_addr),
    .o_in_bounds (w_inb)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state: fixed cycle count per cell, independent of bounds.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.i_start) w_next = ADDR;
      ADDR:    w_next = w_is_check ? WAIT : WRITE;
      WRITE:   w_next = HOLD;
      HOLD:    w_next = w_last ? DONE : ADDR;
      WAIT:    if (w_last_wait) w_next = SAMPLE;
      SAMPLE:  w_next = w_last ? DONE : ADDR;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    w_busy = (r_state != IDLE);
    w_done = (r_state == DONE);
  end

`ifdef PIECE_WRITER_STATS_EN
  logic [$clog2(CELLS+1)-1:0] r_hits;
  assign bus.o_cells_hit = r_hits;
`endif

  // Command latch, registered RAM port, per-cell result accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode      <= '0;
      r_x_anc     <= '0;
      r_y_anc     <= '0;
      r_x_off     <= '0;
      r_y_off     <= '0;
      r_color     <= '0;
      r_idx       <= '0;
      r_wait      <= '0;
      r_ram_addr  <= '0;
      r_ram_wren  <= 1'b0;
      r_ram_wdata <= '0;
      r_collision <= 1'b0;
      r_oob       <= 1'b0;
`ifdef PIECE_WRITER_STATS_EN
      r_hits      <= '0;
`endif
    end else begin
      // Write strobe lands exactly on the WRITE cycle of an in-bounds cell.
      r_ram_wren <= (w_next == WRITE) && w_inb;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_mode      <= bus.i_mode;
            r_x_anc     <= bus.i_x_anc;
            r_y_anc     <= bus.i_y_anc;
            r_x_off     <= bus.i_x_off;
            r_y_off     <= bus.i_y_off;
            r_color     <= bus.i_color;
            r_idx       <= '0;
            r_collision <= 1'b0;
            r_oob       <= 1'b0;
`ifdef PIECE_WRITER_STATS_EN
            r_hits      <= '0;
`endif
          end
        end
        ADDR: begin
          if (w_inb) r_ram_addr <= w_addr;
          r_ram_wdata <= (r_mode == MODE_STAMP) ? r_color : '0;
          r_wait      <= '0;
        end
        WRITE: begin
          if (!w_inb) r_oob <= 1'b1;
`ifdef PIECE_WRITER_STATS_EN
          else        r_hits <= r_hits + 1'b1;
`endif
        end
        HOLD: begin
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        WAIT: begin
          r_wait <= r_wait + 1'b1;
        end
        SAMPLE: begin
          if (!w_inb) begin
            r_oob       <= 1'b1;
            r_collision <= 1'b1;
          end else if (bus.i_ram_rdata != '0) begin
            r_collision <= 1'b1;
`ifdef PIECE_WRITER_STATS_EN
            r_hits      <= r_hits + 1'b1;
`endif
          end
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ram_addr  = r_ram_addr;
  assign bus.o_ram_wren  = r_ram_wren;
  assign bus.o_ram_wdata = r_ram_wdata;
  assign bus.o_busy      = w_busy;
  assign bus.o_done      = w_done;
  assign bus.o_collision = r_collision;
  assign bus.o_oob       = r_oob;

endmodule

`default_nettype wire

// File: tb/tb_piece_ram_writer.sv
// ============================================================================
//  Module      : tb_piece_ram_writer
//  Description : Directed bench for piece_ram_writer with a 240-word board
//                RAM model (registered read, latency 1). With macro
//                PIECE_WRITER_STATS_EN the cells_hit count is also checked.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piece_ram_writer;

  logic clk;
  logic reset;

  piece_ram_writer_if #(.BOARD_W(10), .BOARD_H(24), .DATA_W(6), .CELLS(4), .OFF_W(2)) bus ();

  piece_ram_writer #(
    .BOARD_W(10), .BOARD_H(24), .DATA_W(6), .CELLS(4), .OFF_W(2), .RD_LATENCY(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM model: one write port, registered read.
  logic [5:0] mem [0:239];
  int         wr_count = 0;
  logic       mem_clr;
  logic       pre_we;
  int         pre_a;
  logic [5:0] pre_v;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 240; i++) mem[i] <= '0;
    end else if (pre_we) begin
      mem[pre_a] <= pre_v;
    end else if (bus.o_ram_wren) begin
      mem[bus.o_ram_addr] <= bus.o_ram_wdata;
      wr_count <= wr_count + 1;
    end
    bus.i_ram_rdata <= mem[bus.o_ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    int         xa;
    int         ya;
    logic [7:0] xo;
    logic [7:0] yo;
    logic [5:0] col;
    int         pa;      // preload address, -1 = none
    logic [5:0] pv;
    int         exp_wr;
    int         exp_oob;
    int         exp_coll;
    int         exp_hits;
    int         a0; int v0;
    int         a1; int v1;
    int         a2; int v2;
  } vec_t;

  vec_t vecs [10];

  task automatic preload(input int a, input logic [5:0] v);
    pre_a  = a;
    pre_v  = v;
    pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issue one operation, scramble the inputs after accept, and follow it to done.
  task automatic run_op(input logic [1:0] mode, input int xa, input int ya,
                        input logic [7:0] xo, input logic [7:0] yo,
                        input logic [5:0] col,
                        output int done_cyc, output int busy_cyc,
                        output int oob, output int coll, output int hits);
    bus.i_mode  = mode;
    bus.i_x_anc = 4'(xa);
    bus.i_y_anc = 5'(ya);
    bus.i_x_off = xo;
    bus.i_y_off = yo;
    bus.i_color = col;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_mode  = ~mode;
    bus.i_x_anc = 4'd0;
    bus.i_y_anc = 5'd0;
    bus.i_x_off = 8'hFF;
    bus.i_y_off = 8'hFF;
    bus.i_color = 6'h3E;
    done_cyc = -1;
    busy_cyc = 0;
    oob = 0; coll = 0; hits = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.o_busy) busy_cyc++;
      if (bus.o_done) begin
        done_cyc = cyc;
        oob  = int'(bus.o_oob);
        coll = int'(bus.o_collision);
`ifdef PIECE_WRITER_STATS_EN
        hits = int'(bus.o_cells_hit);
`endif
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  int dc, bc, oo, co, hi, wc0;

  initial begin
    vecs[0] = '{2'd0, 3, 5,  8'hE4, 8'h00, 6'h15, -1,  6'h00, 4, 0, 0, 4, 53, 'h15, 56, 'h15, 57, 0};
    vecs[1] = '{2'd1, 3, 5,  8'hE4, 8'h00, 6'h15, 57,  6'h09, 4, 0, 0, 4, 53, 0,    56, 0,    57, 'h09};
    vecs[2] = '{2'd2, 3, 5,  8'hE4, 8'h00, 6'h15, 55,  6'h03, 0, 0, 1, 1, 55, 3,    54, 0,    57, 'h09};
    vecs[3] = '{2'd2, 3, 5,  8'hE4, 8'h00, 6'h15, 55,  6'h00, 0, 0, 0, 0, 55, 0,    53, 0,    57, 'h09};
    vecs[4] = '{2'd2, 8, 22, 8'h24, 8'h80, 6'h15, -1,  6'h00, 0, 1, 1, 0, 228, 0,   229, 0,   239, 0};
    vecs[5] = '{2'd0, 8, 22, 8'h24, 8'h80, 6'h2A, -1,  6'h00, 2, 1, 0, 2, 227, 0,   228, 'h2A, 229, 'h2A};
    vecs[6] = '{2'd3, 7, 22, 8'h24, 8'h00, 6'h15, -1,  6'h00, 0, 0, 1, 2, 227, 0,   228, 'h2A, 229, 'h2A};
    vecs[7] = '{2'd1, 8, 22, 8'h24, 8'h80, 6'h2A, -1,  6'h00, 2, 1, 0, 2, 227, 0,   228, 0,   229, 0};
    vecs[8] = '{2'd0, 9, 23, 8'h00, 8'h00, 6'h3F, -1,  6'h00, 4, 0, 0, 4, 239, 'h3F, 238, 0,  229, 0};
    vecs[9] = '{2'd2, 0, 23, 8'h00, 8'h55, 6'h15, -1,  6'h00, 0, 1, 1, 0, 230, 0,   239, 'h3F, 0, 0};

    reset = 1'b1; mem_clr = 1'b1; pre_we = 1'b0; pre_a = 0; pre_v = '0;
    bus.i_start = 1'b0; bus.i_mode = '0; bus.i_x_anc = '0; bus.i_y_anc = '0;
    bus.i_x_off = '0; bus.i_y_off = '0; bus.i_color = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_addr", int'(bus.o_ram_addr), 0);
    check("reset_wren", int'(bus.o_ram_wren), 0);
    check("reset_wdata", int'(bus.o_ram_wdata), 0);
    check("reset_busy", int'(bus.o_busy), 0);
    check("reset_done", int'(bus.o_done), 0);
    check("reset_coll", int'(bus.o_collision), 0);
    check("reset_oob", int'(bus.o_oob), 0);
    reset = 1'b0; mem_clr = 1'b0;
    @(posedge clk); #1;

    // Table-driven operations.
    for (int k = 0; k < 10; k++) begin
      if (vecs[k].pa >= 0) preload(vecs[k].pa, vecs[k].pv);
      wc0 = wr_count;
      run_op(vecs[k].mode, vecs[k].xa, vecs[k].ya, vecs[k].xo, vecs[k].yo, vecs[k].col,
             dc, bc, oo, co, hi);
      $display("vector %0d: done cycle %0d", k, dc);
      check($sformatf("v%0d_done_cycle", k), dc, 13);
      check($sformatf("v%0d_busy_cycles", k), bc, 13);
      check($sformatf("v%0d_oob", k), oo, vecs[k].exp_oob);
      check($sformatf("v%0d_collision", k), co, vecs[k].exp_coll);
`ifdef PIECE_WRITER_STATS_EN
      check($sformatf("v%0d_cells_hit", k), hi, vecs[k].exp_hits);
`endif
      @(posedge clk); #1;
      check($sformatf("v%0d_busy_after", k), int'(bus.o_busy), 0);
      check($sformatf("v%0d_coll_held", k), int'(bus.o_collision), vecs[k].exp_coll);
      check($sformatf("v%0d_writes", k), wr_count - wc0, vecs[k].exp_wr);
      check($sformatf("v%0d_mem%0d", k, vecs[k].a0), int'(mem[vecs[k].a0]), vecs[k].v0);
      check($sformatf("v%0d_mem%0d", k, vecs[k].a1), int'(mem[vecs[k].a1]), vecs[k].v1);
      check($sformatf("v%0d_mem%0d", k, vecs[k].a2), int'(mem[vecs[k].a2]), vecs[k].v2);
    end

    // start held high through the whole operation: only one op runs.
    wc0 = wr_count;
    dc = -1;
    bus.i_mode = 2'd0; bus.i_x_anc = 4'd0; bus.i_y_anc = 5'd0;
    bus.i_x_off = 8'hE4; bus.i_y_off = 8'h00; bus.i_color = 6'h07;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.o_done) begin
        dc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    bus.i_start = 1'b0;
    check("hold_start_done_cycle", dc, 13);
    @(posedge clk); #1;
    check("hold_start_idle", int'(bus.o_busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_start_writes", wr_count - wc0, 4);
    check("hold_start_mem3", int'(mem[3]), 'h07);

    // Reset in cycle 5 (cell 1 WRITE) of a STAMP at (0,1).
    wc0 = wr_count;
    bus.i_mode = 2'd0; bus.i_x_anc = 4'd0; bus.i_y_anc = 5'd1;
    bus.i_x_off = 8'hE4; bus.i_y_off = 8'h00; bus.i_color = 6'h11;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_pre_wren", int'(bus.o_ram_wren), 1);
    #1 reset = 1'b1;
    #1;
    check("rst_wren", int'(bus.o_ram_wren), 0);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_done", int'(bus.o_done), 0);
    check("rst_addr", int'(bus.o_ram_addr), 0);
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_writes", wr_count - wc0, 1);
    check("rst_mem10", int'(mem[10]), 'h11);
    check("rst_mem11", int'(mem[11]), 0);
    wc0 = wr_count;
    run_op(2'd0, 0, 1, 8'hE4, 8'h00, 6'h11, dc, bc, oo, co, hi);
    check("rst_restart_done_cycle", dc, 13);
    @(posedge clk); #1;
    check("rst_restart_writes", wr_count - wc0, 4);
    check("rst_restart_mem11", int'(mem[11]), 'h11);
    check("rst_restart_mem13", int'(mem[13]), 'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
